// File: rtl/dff_bist.sv
// dff_bist: LFSR-driven self-test controller for a dff cell or a chain of dff stages
module dff_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LATENCY = 1,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          ERR_CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          dut_rstn,
    output logic                          dut_d,
    input  logic                          dut_q,
    input  logic                          dut_qb,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          rst_err,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic [$clog2(NUM_VECTORS):0]  first_err_idx
);
    localparam int IW = $clog2(NUM_VECTORS) + 1;
    localparam int D  = DUT_LATENCY + 1;
    localparam int CW = $clog2(NUM_VECTORS + D + 2) + 1;
    localparam logic [15:0] SEED_I = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {IDLE, DUT_RST, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   rst_err_q, rst_err_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [IW-1:0]          fei_q, fei_d;
    logic [D-1:0]           pv_q, pv_d;
    logic [D-1:0]           pe_q, pe_d;
    logic [IW-1:0]          pi_q [D];
    logic [IW-1:0]          pi_d [D];
    logic                   dut_rstn_q, dut_rstn_d;
    logic                   dut_d_q, dut_d_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   chk, bad;

    // Next-state, stimulus, compare pipeline and result bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        rst_err_d = rst_err_q;
        err_d     = err_q;
        fei_d     = fei_q;
        pv_d      = {pv_q[D-2:0], state_q == RUN};
        pe_d      = {pe_q[D-2:0], lfsr_q[15]};
        pi_d[0]   = cnt_q[IW-1:0];
        for (int i = 1; i < D; i++) pi_d[i] = pi_q[i-1];
        chk = pv_q[D-1] && (state_q == RUN || state_q == DRAIN);
        bad = (dut_q != pe_q[D-1]) || (dut_qb == dut_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DUT_RST;
                    cnt_d     = '0;
                    lfsr_d    = SEED_I;
                    rst_err_d = 1'b0;
                    err_d     = '0;
                    fei_d     = '1;
                end
            end
            DUT_RST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    rst_err_d = rst_err_q | dut_q | ~dut_qb;
                end
            end
            RUN: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_VECTORS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(D - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (chk && bad) begin
            err_d = (&err_q) ? err_q : err_q + ERR_CNT_W'(1);
            if (&fei_q) fei_d = pi_q[D-1];
        end
        dut_d_d    = (state_q == RUN) && lfsr_q[15];
        dut_rstn_d = state_d != DUT_RST;
        busy_d     = state_d == DUT_RST || state_d == RUN || state_d == DRAIN;
        done_d     = state_d == DONE;
        pass_d     = done_d && err_d == '0 && !rst_err_d;
    end

    // State and registered outputs; rst aborts any test in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lfsr_q     <= SEED_I;
            rst_err_q  <= 1'b0;
            err_q      <= '0;
            fei_q      <= '1;
            pv_q       <= '0;
            pe_q       <= '0;
            pi_q       <= '{default: '0};
            dut_rstn_q <= 1'b1;
            dut_d_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            rst_err_q  <= rst_err_d;
            err_q      <= err_d;
            fei_q      <= fei_d;
            pv_q       <= pv_d;
            pe_q       <= pe_d;
            pi_q       <= pi_d;
            dut_rstn_q <= dut_rstn_d;
            dut_d_q    <= dut_d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign dut_rstn      = dut_rstn_q;
    assign dut_d         = dut_d_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign rst_err       = rst_err_q;
    assign err_count     = err_q;
    assign first_err_idx = fei_q;
endmodule
